// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: adds CHUNK bits per clock and ripples the
// carry through a registered flop. It has valid/ready handshakes on both sides.
`timescale 1ns/1ps
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NCH   = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
    $fatal(1, "seq_chunk_adder: CHUNK must be in 1..WIDTH and divide WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               overflow_q, overflow_d;
  logic               zero_q, zero_d;

  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK:0]     chunk_res;
  logic               msb_carry_in;
  logic [WIDTH-1:0]   sum_shift;
  logic               last_chunk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign last_chunk = (state_q == RUN) && (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Operands shift right one chunk per cycle. Result chunks enter at the top,
  // so after NCH shifts chunk 0 ends up at the LSB.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    a_chunk      = a_q[CHUNK-1:0];
    b_chunk      = b_q[CHUNK-1:0];
    chunk_res    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_res[CHUNK-1];
    sum_shift    = (sum_q >> CHUNK) | (WIDTH'(chunk_res[CHUNK-1:0]) << (WIDTH - CHUNK));

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          idx_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chunk_res[CHUNK];
        sum_d   = sum_shift;
        if (last_chunk) begin
          idx_d      = '0;
          cout_d     = chunk_res[CHUNK];
          overflow_d = msb_carry_in ^ chunk_res[CHUNK];
          zero_d     = (sum_shift == '0);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Randomised scoreboard bench for seq_chunk_adder (32/8 and 16/16 instances)
// checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_seq_chunk_adder;

  localparam int N1 = 4;
  localparam int N2 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic        in_valid1 = 1'b0, in_ready1, sub1 = 1'b0, cin1 = 1'b0;
  logic [31:0] a1 = '0, b1 = '0, sum1;
  logic        out_valid1, out_ready1 = 1'b1, cout1, ovf1, zero1;

  logic        in_valid2 = 1'b0, in_ready2, sub2 = 1'b0, cin2 = 1'b0;
  logic [15:0] a2 = '0, b2 = '0, sum2;
  logic        out_valid2, out_ready2 = 1'b1, cout2, ovf2, zero2;

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .sub(sub1), .cin(cin1), .out_valid(out_valid1),
    .out_ready(out_ready1), .sum(sum1), .cout(cout1), .overflow(ovf1), .zero(zero1)
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .sub(sub2), .cin(cin2), .out_valid(out_valid2),
    .out_ready(out_ready2), .sum(sum2), .cout(cout2), .overflow(ovf2), .zero(zero2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int compared = 0;
  int mismatched = 0;
  bit rand_ready = 1'b0;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc;
  } exp_t;

  exp_t sb1[$];
  exp_t sb2[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain signed/unsigned arithmetic: a+b+cin or a-b-cin over w bits.
  function automatic exp_t refModel(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic sub, input logic cin);
    exp_t   e;
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint ua   = longint'(a) & m;
    longint ub   = longint'(b) & m;
    longint c    = longint'(cin);
    longint sa   = (ua >= half) ? ua - (m + 1) : ua;
    longint sb   = (ub >= half) ? ub - (m + 1) : ub;
    longint ures, sres;
    if (!sub) begin
      ures   = ua + ub + c;
      sres   = sa + sb + c;
      e.cout = (ures > m);
    end else begin
      ures   = ua - ub - c;
      sres   = sa - sb - c;
      e.cout = (ures >= 0);
    end
    e.sum  = 32'(ures & m);
    e.zero = ((ures & m) == 0);
    e.ovf  = (sres >= half) || (sres < -half);
    e.acc  = 0;
    return e;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic applyStimulus(input bit use2, input logic [31:0] a, input logic [31:0] b,
                               input logic sub, input logic cin, output int acc);
    int   waited = 0;
    logic rdy;
    exp_t e;
    acc = -1;
    if (!use2) begin
      in_valid1 = 1'b1; a1 = a; b1 = b; sub1 = sub; cin1 = cin;
    end else begin
      in_valid2 = 1'b1; a2 = a[15:0]; b2 = b[15:0]; sub2 = sub; cin2 = cin;
    end
    forever begin
      rdy = use2 ? in_ready2 : in_ready1;
      @(posedge clk);
      #1;
      if (rdy) break;
      waited++;
      if (waited > 60) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL accept_timeout: in_ready never seen after %0d cycles", waited);
        if (!use2) in_valid1 = 1'b0; else in_valid2 = 1'b0;
        return;
      end
    end
    acc = cyc;
    e = refModel(use2 ? 16 : 32, a, b, sub, cin);
    e.acc = acc;
    if (!use2) begin
      sb1.push_back(e);
      in_valid1 = 1'b0;
    end else begin
      sb2.push_back(e);
      in_valid2 = 1'b0;
    end
  endtask

  task automatic waitDrain(input bit use2);
    int n = 0;
    while ((use2 ? sb2.size() : sb1.size()) != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) checkOutput("drain_timeout", 32'(n), 32'd0);
  endtask

  // Monitor for the 32/8 instance: latency on rise, full compare on handshake.
  logic prev_valid1 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid1 && !prev_valid1 && sb1.size() > 0)
      checkOutput("latency1", 32'(cyc - sb1[0].acc), 32'(N1));
    if (out_valid1 && out_ready1) begin
      if (sb1.size() == 0) begin
        checkOutput("unexpected_out1", 32'd1, 32'd0);
      end else begin
        e = sb1.pop_front();
        checkOutput("sum1", sum1, e.sum);
        checkOutput("cout1", 32'(cout1), 32'(e.cout));
        checkOutput("overflow1", 32'(ovf1), 32'(e.ovf));
        checkOutput("zero1", 32'(zero1), 32'(e.zero));
      end
    end
    prev_valid1 = out_valid1;
  end

  logic prev_valid2 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid2 && !prev_valid2 && sb2.size() > 0)
      checkOutput("latency2", 32'(cyc - sb2[0].acc), 32'(N2));
    if (out_valid2 && out_ready2) begin
      if (sb2.size() == 0) begin
        checkOutput("unexpected_out2", 32'd1, 32'd0);
      end else begin
        e = sb2.pop_front();
        checkOutput("sum2", {16'h0, sum2}, e.sum);
        checkOutput("cout2", 32'(cout2), 32'(e.cout));
        checkOutput("overflow2", 32'(ovf2), 32'(e.ovf));
        checkOutput("zero2", 32'(zero2), 32'(e.zero));
      end
    end
    prev_valid2 = out_valid2;
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready1 = 1'($urandom_range(0, 1));
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_sum"}, sum1, 32'h0);
    checkOutput({tag, "_cout"}, 32'(cout1), 32'd0);
    checkOutput({tag, "_ovf"}, 32'(ovf1), 32'd0);
    checkOutput({tag, "_zero"}, 32'(zero1), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid1), 32'd0);
    checkOutput({tag, "_in_ready"}, 32'(in_ready1), 32'd1);
  endtask

  initial begin
    int   acc, prev_acc, n;
    exp_t ea;

    #2 rst_n = 1'b0;
    #1 checkResetValues("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed add/sub cases");
    applyStimulus(0, 32'h0000_000B, 32'h0000_0004, 1'b0, 1'b0, acc);
    applyStimulus(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, acc);
    applyStimulus(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, acc);
    applyStimulus(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, acc);
    applyStimulus(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, acc);
    applyStimulus(0, 32'h0000_0009, 32'h0000_0004, 1'b1, 1'b1, acc);
    applyStimulus(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, acc);
    waitDrain(0);

    $display("[TB] backpressure");
    out_ready1 = 1'b0;
    ea = refModel(32, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    applyStimulus(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, acc);
    in_valid1 = 1'b1; a1 = 32'hDEAD_BEEF; b1 = 32'h0000_0011; sub1 = 1'b1; cin1 = 1'b0;
    n = 0;
    while (!out_valid1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_out_valid", 32'(out_valid1), 32'd1);
      checkOutput("bp_in_ready", 32'(in_ready1), 32'd0);
      checkOutput("bp_sum", sum1, ea.sum);
      checkOutput("bp_cout", 32'(cout1), 32'(ea.cout));
      @(posedge clk);
      #1;
    end
    out_ready1 = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_idle_in_ready", 32'(in_ready1), 32'd1);
    applyStimulus(0, 32'hDEAD_BEEF, 32'h0000_0011, 1'b1, 1'b0, acc);
    waitDrain(0);

    $display("[TB] reset mid-run");
    applyStimulus(0, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0, acc);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 checkResetValues("midrun_reset");
    sb1.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, 32'd3, 32'd4, 1'b0, 1'b0, acc);
    waitDrain(0);

    $display("[TB] random traffic with random out_ready");
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(0, pickOperand(), pickOperand(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), acc);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready1 = 1'b1;
    @(posedge clk);
    #1;
    waitDrain(0);

    $display("[TB] single-chunk instance");
    applyStimulus(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, acc);
    prev_acc = acc;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, pickOperand(), pickOperand(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), acc);
      checkOutput("b2b_gap", 32'(acc - prev_acc), 32'd3);
      prev_acc = acc;
    end
    waitDrain(1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
Parametrised multi-cycle add/subtract unit. It adds WIDTH-bit operands CHUNK bits per clock, rippling the carry between chunks in a registered carry flop. It supports add, subtract and carry/borrow-in, and reports carry-out, signed overflow and a zero flag. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits added per cycle; 1 <= CHUNK <= WIDTH.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operands and mode are valid.
in_ready  output  1  unit can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
sub  input  1  0 = add, 1 = subtract (a - b).
cin  input  1  carry-in (add) or borrow-in (sub).
out_valid  output  1  result is valid.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  result.
cout  output  1  final carry-out (sub: 1 = no borrow).
overflow  output  1  two's-complement signed overflow.
zero  output  1  sum == 0.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- NCH = WIDTH/CHUNK. Parameter legality is checked at elaboration; an illegal combination is a fatal error.
- FSM states and transitions:
  - IDLE: in_ready = 1 (combinational from state). in_valid & in_ready at an edge captures the operands and goes to RUN.
  - RUN: on each edge, processes one chunk, then increments the chunk index. After NCH chunks it goes to DONE.
  - DONE: out_valid = 1. out_valid & out_ready at an edge goes to IDLE.
- Capture:
  - a_r = a.
  - b_r = sub ? ~b : b.
  - carry = cin ^ sub. This gives sub,cin=0 -> a-b and sub,cin=1 -> a-b-1.
- Chunk i, processed LSB chunk first:
  - {carry, sum[i*CHUNK +: CHUNK]} = a_r chunk + b_r chunk + carry.
  - On the last chunk, the carry into bit WIDTH-1 is also registered, for the overflow calculation.
- Results:
  - cout = final carry.
  - overflow = carry into MSB ^ carry out of MSB.
  - zero = (sum == 0).
  - All four are registered and valid when out_valid rises.
- Latency: out_valid is high NCH cycles after the accepting edge. Throughput is one operation per NCH+2 cycles when out_ready is held high.
- in_ready = 0 in RUN and DONE. in_valid, a, b, sub and cin are ignored outside IDLE. No new operation overlaps a pending result.
- Operand inputs may change after the accepting edge. The captured copies are used.
- Backpressure: while in DONE with out_ready = 0, sum, cout, overflow, zero and out_valid hold stable indefinitely.
- out_ready is a don't-care outside DONE.
- Reset (asynchronous assert, any state, including mid-RUN):
  - state = IDLE, chunk index = 0, carry = 0.
  - sum = 0, cout = 0, overflow = 0, zero = 0, out_valid = 0, in_ready = 1.
  - Any operation in progress is discarded.
- Reset deassertion is synchronised externally. The block accepts in_valid on the first edge after rst_n rises.
- CHUNK == WIDTH is legal: NCH = 1, and out_valid rises 1 cycle after acceptance.
- Carry propagates across all chunk boundaries with no loss, including all-ones wrap-around.

Test Plan:
1. WIDTH=32, CHUNK=8, add, a=0x0000000B, b=0x00000004, cin=0 -> sum=0x0000000F, cout=0, overflow=0, zero=0; out_valid exactly 4 cycles after acceptance.
2. add, a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, zero=1, overflow=0 (carry ripples through all 4 chunks). add, a=0x7FFFFFFF, b=1 -> sum=0x80000000, overflow=1, cout=0.
3. Subtract cases:
   - sub, a=5, b=7, cin=0 -> sum=0xFFFFFFFE, cout=0, overflow=0.
   - sub, a=0x80000000, b=1 -> sum=0x7FFFFFFF, cout=1, overflow=1.
   - sub, a=9, b=4, cin=1 -> sum=4, cout=1.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> outputs stable, in_ready=0, new operands not taken. Raise out_ready -> IDLE next cycle, then the pending operands are accepted.
5. Assert rst_n=0 mid-RUN, after 2 chunks -> all outputs at reset values immediately (asynchronously), in_ready=1. A following add of 3+4 returns sum=7 with normal latency.
6. WIDTH=16, CHUNK=16: add a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, zero=1, out_valid 1 cycle after acceptance. Back-to-back operations with out_ready=1 are accepted every 3 cycles.
